// File: rtl/hamming_pkg.sv
// hamming_pkg: shared SECDED (8,4) codeword layout and encode function
package hamming_pkg;
  localparam int CODE_W = 8;
  localparam int DATA_W = 4;
  localparam int POS_P1 = 0;
  localparam int POS_P2 = 1;
  localparam int POS_D1 = 2;
  localparam int POS_P3 = 3;
  localparam int POS_D2 = 4;
  localparam int POS_D3 = 5;
  localparam int POS_D4 = 6;
  localparam int POS_P4 = 7;

  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] data);
    logic [CODE_W-1:0] c;
    c = '0;
    c[POS_D1] = data[0];
    c[POS_D2] = data[1];
    c[POS_D3] = data[2];
    c[POS_D4] = data[3];
    c[POS_P1] = data[0] ^ data[1] ^ data[3];
    c[POS_P2] = data[0] ^ data[2] ^ data[3];
    c[POS_P3] = data[1] ^ data[2] ^ data[3];
    // overall parity makes every clean codeword even-weight
    c[POS_P4] = ^c[POS_D4:POS_P1];
    return c;
  endfunction
endpackage

// File: rtl/hamming_err_inject.sv
// hamming_err_inject: holds the armed corruption mask and the count of words still to corrupt
module hamming_err_inject
  import hamming_pkg::*;
#(
  parameter int INJ_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 arm,
  input  logic [CODE_W-1:0]    mask_in,
  input  logic [INJ_CNT_W-1:0] num_in,
  input  logic                 accept,
  output logic [CODE_W-1:0]    xor_mask,
  output logic                 active
);
  logic [CODE_W-1:0]    mask_q, mask_d;
  logic [INJ_CNT_W-1:0] remaining_q, remaining_d;

  always_comb begin
    active      = remaining_q != '0;
    xor_mask    = active ? mask_q : '0;
    mask_d      = arm ? mask_in : mask_q;
    // a same-cycle arm overrides the decrement; the accepted word already used the old state
    remaining_d = arm ? num_in : (accept && active) ? remaining_q - INJ_CNT_W'(1) : remaining_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mask_q      <= '0;
      remaining_q <= '0;
    end else begin
      mask_q      <= mask_d;
      remaining_q <= remaining_d;
    end
  end
endmodule

// File: rtl/hamming_encoder.sv
// hamming_encoder: streaming SECDED (8,4) encoder with one-entry output register and error injection
module hamming_encoder
  import hamming_pkg::*;
#(
  parameter int INJ_CNT_W = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    data_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CODE_W-1:0]    code_out,
  input  logic                 inj_arm,
  input  logic [CODE_W-1:0]    inj_mask_in,
  input  logic [INJ_CNT_W-1:0] inj_num_in,
  output logic                 inj_active,
  output logic [CNT_W-1:0]     word_cnt
);
  logic              out_valid_q, out_valid_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              accept, xfer;
  logic [CODE_W-1:0] xor_mask;

  hamming_err_inject #(.INJ_CNT_W(INJ_CNT_W)) u_inj (
    .clk      (clk),
    .rstn     (rstn),
    .arm      (inj_arm),
    .mask_in  (inj_mask_in),
    .num_in   (inj_num_in),
    .accept   (accept),
    .xor_mask (xor_mask),
    .active   (inj_active)
  );

  always_comb begin
    in_ready    = !out_valid_q || out_ready;
    accept      = in_valid && in_ready;
    xfer        = out_valid_q && out_ready;
    code_d      = accept ? encode(data_in) ^ xor_mask : code_q;
    out_valid_d = accept || (out_valid_q && !out_ready);
    word_cnt_d  = xfer ? word_cnt_q + CNT_W'(1) : word_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      code_q      <= '0;
      word_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      code_q      <= code_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign code_out  = code_q;
  assign word_cnt  = word_cnt_q;
endmodule

// File: tb/tb_hamming_encoder.sv
// tb_hamming_encoder: directed checks of encoding, handshake, injection and sync reset
module tb_hamming_encoder;
  logic       clk = 1'b0;
  logic       rstn;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] data_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] code_out;
  logic       inj_arm;
  logic [7:0] inj_mask_in;
  logic [3:0] inj_num_in;
  logic       inj_active;
  logic [15:0] word_cnt;
  int n_pass = 0;
  int n_total = 0;

  hamming_encoder #(.INJ_CNT_W(4), .CNT_W(16)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_in     (data_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .code_out    (code_out),
    .inj_arm     (inj_arm),
    .inj_mask_in (inj_mask_in),
    .inj_num_in  (inj_num_in),
    .inj_active  (inj_active),
    .word_cnt    (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [7:0] mask, input logic [3:0] num);
    inj_arm = 1'b1;
    inj_mask_in = mask;
    inj_num_in = num;
    tick();
    inj_arm = 1'b0;
  endtask

  task automatic send(input logic [3:0] d);
    in_valid = 1'b1;
    data_in = d;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    rstn = 1'b0;
    in_valid = 1'b0;
    data_in = '0;
    out_ready = 1'b0;
    inj_arm = 1'b0;
    inj_mask_in = '0;
    inj_num_in = '0;
    tick();
    tick();
    rstn = 1'b1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_code", 32'(code_out), 32'h00);
    check("rst_inj_active", 32'(inj_active), 0);
    check("rst_word_cnt", 32'(word_cnt), 0);
    check("rst_in_ready", 32'(in_ready), 1);

    out_ready = 1'b1;
    send(4'h0); check("enc_0", 32'(code_out), 32'h00); check("enc_0_valid", 32'(out_valid), 1);
    send(4'hB); check("enc_B", 32'(code_out), 32'h55);
    send(4'hF); check("enc_F", 32'(code_out), 32'hFF);
    send(4'h1); check("enc_1", 32'(code_out), 32'h87);
    idle();
    check("enc_drained", 32'(out_valid), 0);
    check("enc_hold_code", 32'(code_out), 32'h87);
    check("enc_word_cnt", 32'(word_cnt), 4);

    out_ready = 1'b0;
    send(4'h2);
    data_in = 4'h3;
    for (int i = 0; i < 5; i++) begin
      check("bp_code_stable", 32'(code_out), 32'h99);
      check("bp_valid_stable", 32'(out_valid), 1);
      check("bp_in_ready", 32'(in_ready), 0);
      tick();
    end
    check("bp_word_cnt_held", 32'(word_cnt), 4);
    out_ready = 1'b1;
    #1 check("bp_in_ready_release", 32'(in_ready), 1);
    tick();
    check("bp_second", 32'(code_out), 32'h1E);
    send(4'h4); check("bp_third", 32'(code_out), 32'hAA);
    idle();
    check("bp_drained", 32'(out_valid), 0);
    check("bp_word_cnt", 32'(word_cnt), 7);

    arm(8'h04, 4'd1);
    check("sb_armed", 32'(inj_active), 1);
    send(4'hB); check("sb_corrupt", 32'(code_out), 32'h51); check("sb_inj_done", 32'(inj_active), 0);
    send(4'hB); check("sb_clean", 32'(code_out), 32'h55);
    idle();

    arm(8'h05, 4'd2);
    send(4'hB); check("db_first", 32'(code_out), 32'h50); check("db_still_active", 32'(inj_active), 1);
    send(4'hB); check("db_second", 32'(code_out), 32'h50); check("db_inj_done", 32'(inj_active), 0);
    idle();

    in_valid = 1'b1;
    data_in = 4'hF;
    arm(8'h80, 4'd1);
    check("col_old_state", 32'(code_out), 32'hFF);
    check("col_armed", 32'(inj_active), 1);
    send(4'h0); check("col_new_mask", 32'(code_out), 32'h80); check("col_inj_done", 32'(inj_active), 0);
    idle();

    arm(8'h00, 4'd1);
    send(4'h1); check("zero_mask_clean", 32'(code_out), 32'h87); check("zero_mask_dec", 32'(inj_active), 0);
    idle();

    arm(8'h04, 4'd3);
    arm(8'h04, 4'd0);
    check("disarm", 32'(inj_active), 0);
    send(4'hB); check("disarm_clean", 32'(code_out), 32'h55);
    idle();
    check("total_word_cnt", 32'(word_cnt), 15);

    arm(8'h04, 4'd3);
    send(4'h1);
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("mid_corrupt", 32'(code_out), 32'h83);
    #1 rstn = 1'b0;
    #2 rstn = 1'b1;
    tick();
    check("glitch_valid", 32'(out_valid), 1);
    check("glitch_code", 32'(code_out), 32'h83);
    check("glitch_inj", 32'(inj_active), 1);
    rstn = 1'b0;
    #2;
    check("pre_edge_valid", 32'(out_valid), 1);
    check("pre_edge_cnt", 32'(word_cnt), 15);
    tick();
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_inj", 32'(inj_active), 0);
    check("mid_rst_cnt", 32'(word_cnt), 0);
    check("mid_rst_code", 32'(code_out), 32'h00);
    rstn = 1'b1;
    out_ready = 1'b1;
    send(4'hB); check("post_rst_clean", 32'(code_out), 32'h55);
    idle();
    check("post_rst_cnt", 32'(word_cnt), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/hamming_encoder.md
Name: hamming_encoder

Overview:
Streaming SECDED (8,4) Hamming encoder. It is the transmit-side counterpart of the team's Hamming decoder: it takes 4-bit data words over a valid/ready handshake and emits 8-bit codewords in the decoder's bit layout. It includes a one-entry output register and a programmable error-injection unit, so the decoder's single-bit and double-bit paths can be exercised end-to-end.

Parameters:
INJ_CNT_W, 4, width of the injection word counter (up to 2^INJ_CNT_W-1 corrupted words per arm)
CNT_W, 16, width of the encoded-word counter

Ports:
clk  input  1  rising-edge clock
rstn  input  1  synchronous active-low reset
in_valid  input  1  data_in holds a valid word
in_ready  output  1  encoder can accept a word this cycle
data_in  input  4  {D4,D3,D2,D1}; data_in[0]=D1
out_valid  output  1  code_out holds a valid codeword
out_ready  input  1  downstream accepts code_out this cycle
code_out  output  8  [0]P1 [1]P2 [2]D1 [3]P3 [4]D2 [5]D3 [6]D4 [7]P4
inj_arm  input  1  one-cycle pulse; loads inj_mask_in and inj_num_in
inj_mask_in  input  8  XOR mask applied to the codeword when injecting
inj_num_in  input  INJ_CNT_W  number of subsequent accepted words to corrupt
inj_active  output  1  injection is pending (remaining count > 0)
word_cnt  output  CNT_W  count of codewords transferred out (out_valid&&out_ready)

Behaviour:
- Reset: sampled only on clk rising edge with rstn=0. Then out_valid=0, code_out=8'h00, inj_active=0, remaining count=0, stored mask=8'h00, word_cnt=0. A reset mid-transfer drops the held word with no output.
- Parity equations: P1=D1^D2^D4, P2=D1^D3^D4, P3=D2^D3^D4, P4=XOR of code bits [6:0]. Every uncorrupted codeword has even overall parity.
- Handshake: in_ready = !out_valid || out_ready (combinational). The block is full-throughput, one word per cycle.
- Accept: when in_valid && in_ready, code_out <= encode(data_in) ^ (inj_active ? mask : 8'h00), and out_valid <= 1. Latency is 1 cycle from accept to out_valid.
- Drain: when out_valid && out_ready && !(in_valid && in_ready), out_valid <= 0. code_out holds its value.
- Stall: while out_valid && !out_ready, code_out and out_valid must stay stable and in_ready=0.
- Simultaneous drain and accept: new word is loaded and out_valid stays 1, with no bubble.
- in_valid asserted with in_ready=0: the word is not consumed; the sender holds it.
- Injection: inj_arm loads mask <= inj_mask_in and remaining <= inj_num_in, overriding any pending count.
  - Each accepted word while remaining>0 is XORed with the mask, then remaining decrements.
  - inj_active = (remaining != 0).
  - If inj_arm and an accept occur in the same cycle, the accepted word uses the OLD state; the new arm applies from the next accept.
  - inj_num_in=0 disarms.
  - Mask 8'h00 corrupts nothing but still decrements.
- word_cnt increments on each out_valid && out_ready and wraps modulo 2^CNT_W.

Decomposition:
- Package hamming_pkg holds:
  - bit-position localparams (POS_P1=0, POS_P2=1, POS_D1=2, POS_P3=3, POS_D2=4, POS_D3=5, POS_D4=6, POS_P4=7);
  - CODE_W=8, DATA_W=4;
  - a pure function encode(data[3:0]) -> code[7:0], shared with the decoder.
- One sub-module, hamming_err_inject: owns the mask and count registers and outputs the XOR mask for the current accept. The top level holds the output register and handshake.

Test Plan:
- Encode table: send 4'h0, 4'hB, 4'hF, 4'h1 with out_ready=1 -> code_out 8'h00, 8'h55, 8'hFF, 8'h87, each one cycle after accept; word_cnt=4.
- Back-pressure: in_valid=1 for 3 words, out_ready=0 for 5 cycles -> first codeword held stable; in_ready=0; no words lost or duplicated after out_ready=1; order preserved.
- Single-bit injection: inj_arm with mask 8'h04, num=1, then send 4'hB -> code_out 8'h51, inj_active drops to 0; next 4'hB -> 8'h55. Feeding the decoder gives err_correctable=1, data_out=4'hB.
- Double-bit injection: mask 8'h05, num=2, send 4'hB twice -> 8'h50 both times. Decoder flags err_uncorrectable.
- Arm/accept collision: inj_arm (mask 8'h80, num=1) in the same cycle as accepting 4'hF -> 8'hFF uncorrupted; the next word 4'h0 -> 8'h80.
- Sync reset mid-stream: rstn=0 for one edge while out_valid=1 and injection pending -> out_valid=0, inj_active=0, word_cnt=0. Asserting rstn=0 between edges has no effect until the next edge.
